flag_gen: RTL



---
 rtl/flag_gen.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/flag_gen.sv
`default_nettype none
// ============================================================================
//  Module   : flag_gen
//  Purpose  : Condition-flag producer. Derives Z/N/V from the EX-stage ALU
//             result, holds one pending (MEM-stage) update that is forwarded
//             to branch logic, commits it to the architectural flag register,
//             and keeps a shadow stack for interrupt save/restore.
//  Revision : 1.0  initial release
// ============================================================================
module flag_gen #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  input  logic               ex_set_flags,
  input  logic [1:0]         ex_op,
  input  logic [DATA_W-1:0]  ex_a,
  input  logic [DATA_W-1:0]  ex_b,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic               stall,
  input  logic               flush,
  input  logic               save_flags,
  input  logic               restore_flags,
  output logic               flag_z,
  output logic               flag_n,
  output logic               flag_v,
  output logic [2:0]         arch_flags,
  output logic [DEPTH_W-1:0] stack_depth,
  output logic               stack_err
);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOGIC = 2'b10;
  localparam logic [1:0] OP_NONE  = 2'b11;

  localparam int                 MSB       = DATA_W - 1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

  // EX-stage flag candidates
  logic       ex_z;
  logic       ex_n;
  logic       ex_v;
  logic       cap;

  // Pending (MEM-stage) update and committed flags
  logic       pend_valid;
  logic [2:0] pend;
  logic [2:0] arch_q;
  logic [2:0] fwd;

  // Shadow stack
  logic [2:0]         stack_mem [DEPTH];
  logic [DEPTH_W-1:0] depth_q;
  logic [2:0]         stack_top;
  logic               stack_full;
  logic               stack_empty;
  logic               save_only;
  logic               restore_only;
  logic               do_push;
  logic               do_pop;
  logic               err_next;
  logic               err_q;

  // Only the sign bits of the operands participate in overflow detection.
  logic unused_ok;
  assign unused_ok = ^{ex_a[MSB-1:0], ex_b[MSB-1:0]};

  // Combinational Z/N/V from the EX result; SUB overflow uses the raw B sign.
  always_comb begin
    ex_z = (ex_result == '0);
    ex_n = ex_result[MSB];
    ex_v = 1'b0;
    case (ex_op)
      OP_ADD:   ex_v = (ex_a[MSB] == ex_b[MSB]) & (ex_result[MSB] != ex_a[MSB]);
      OP_SUB:   ex_v = (ex_a[MSB] != ex_b[MSB]) & (ex_result[MSB] != ex_a[MSB]);
      OP_LOGIC: ex_v = 1'b0;
      default:  ex_v = 1'b0;
    endcase
  end

  // Any restore request (legal or not) blocks the EX capture that cycle.
  assign cap = ex_valid & ex_set_flags & (ex_op != OP_NONE)
             & ~stall & ~flush & ~restore_flags;

  // Branch logic sees the youngest flags: pending if present, else committed.
  assign fwd = pend_valid ? pend : arch_q;

  // Stack operation decode; a simultaneous save/restore is treated as illegal.
  assign stack_full   = (depth_q == DEPTH_MAX);
  assign stack_empty  = (depth_q == '0);
  assign save_only    = save_flags & ~restore_flags;
  assign restore_only = restore_flags & ~save_flags;
  assign do_push      = save_only & ~stack_full;
  assign do_pop       = restore_only & ~stack_empty;
  assign err_next     = (save_flags & restore_flags)
                      | (save_only & stack_full)
                      | (restore_only & stack_empty);

  // Top-of-stack read as a mux on depth, avoiding an oversized array index.
  always_comb begin
    stack_top = 3'b000;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == DEPTH_W'(i + 1)) begin
        stack_top = stack_mem[i];
      end
    end
  end

  // Pending stage: loads on capture, otherwise empties (its value commits).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend       <= 3'b000;
    end else begin
      pend_valid <= cap;
      if (cap) begin
        pend <= {ex_z, ex_n, ex_v};
      end
    end
  end

  // Architectural flags: a successful restore overrides the pending commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arch_q <= 3'b000;
    end else if (do_pop) begin
      arch_q <= stack_top;
    end else if (pend_valid) begin
      arch_q <= pend;
    end
  end

  // Stack storage: a push writes the forwarded view into the next free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stack_mem[i] <= 3'b000;
      end
    end else if (do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (depth_q == DEPTH_W'(i)) begin
          stack_mem[i] <= fwd;
        end
      end
    end
  end

  // Stack occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
    end else if (do_push) begin
      depth_q <= depth_q + 1'b1;
    end else if (do_pop) begin
      depth_q <= depth_q - 1'b1;
    end
  end

  // Registered one-cycle error pulse for illegal stack requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_next;
    end
  end

  assign flag_z      = fwd[2];
  assign flag_n      = fwd[1];
  assign flag_v      = fwd[0];
  assign arch_flags  = arch_q;
  assign stack_depth = depth_q;
  assign stack_err   = err_q;

endmodule
`default_nettype wire
